conv1d_pipelined_engine: RTL and testbench

- Parametrised successor of the CFU 1-D convolution engine.
- Holds an int8 input ring buffer and an int8 filter buffer, loaded over the CFU command interface.
- Computes one dot product per start command for one output position: sum of filter[k] * (input[k] + input_offset), 32-bit.
- Generalised in kernel length, MAC lanes, channel count and I/O packing. Adds a two-stage MAC pipeline, arbitrary depth with tail masking, per-lane ring wrap, auto-advancing start row, busy/error status and asynchronous reset.
- Sits between the CPU CFU port and the external quantisation stage; it returns the raw accumulator.

---
 rtl/conv1d_pipelined_engine.sv | 209 ++++++++++++++++++++
 tb/tb_conv1d_pipelined_engine.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_pipelined_engine.sv
// conv1d_pipelined_engine: int8 ring/filter buffers with a LANES-wide,
// two-stage MAC pipeline computing one 32-bit output position per start.
// Ports: clk, rst (async, active high), en/cmd/inp0/inp1 command in,
//        ret registered response, busy high while the pipeline holds work.
module conv1d_pipelined_engine #(
    parameter int KERNEL_LENGTH      = 8,
    parameter int MAX_INPUT_CHANNELS = 128,
    parameter int LANES              = 8,
    parameter int INT32_SIZE         = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [6:0]            cmd,
    input  logic [INT32_SIZE-1:0] inp0,
    input  logic [INT32_SIZE-1:0] inp1,
    output logic [INT32_SIZE-1:0] ret,
    output logic                  busy
);

    localparam int FILT_SZ = KERNEL_LENGTH * MAX_INPUT_CHANNELS;
    localparam int RING_SZ = (KERNEL_LENGTH + 1) * MAX_INPUT_CHANNELS;
    localparam int FA_W    = $clog2(FILT_SZ);
    localparam int RA_W    = $clog2(RING_SZ);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    logic [7:0] filt_mem [FILT_SZ];
    logic [7:0] ring_mem [RING_SZ];

    state_t      state_q, state_d;
    logic        drain_q, drain_d;
    logic        done, issue;

    logic [31:0] ret_q, acc_q;
    logic        err_q;
    logic [31:0] offset_q, depth_q, start_x_q;
    logic [2:0]  rw_bytes_q;

    // Job parameters latched at start; later command writes wait for the next start.
    logic [31:0] run_off_q, cur_k_q, cur_ring_q;
    logic [31:0] k_q, ia_q;
    logic [31:0] s1_sum_q;
    logic        s1_v_q;

    logic        start, depth_ok, last_issue;
    logic        wr_in, wr_flt;
    logic [3:0]  be;
    logic [31:0] new_k, new_ring, new_div, ia_start, ring_div;
    logic [31:0] lane_sum, rd_in, rd_flt;

    assign start    = en && (cmd == 7'd6 || cmd == 7'd19);
    assign depth_ok = (depth_q != 32'd0) && (depth_q <= 32'(MAX_INPUT_CHANNELS));
    assign new_k    = 32'(KERNEL_LENGTH) * depth_q;
    assign new_ring = 32'(KERNEL_LENGTH + 1) * depth_q;
    assign new_div  = depth_ok ? new_ring : 32'd1;
    assign ia_start = (start_x_q * depth_q) % new_div;
    assign ring_div = (cur_ring_q == 32'd0) ? 32'd1 : cur_ring_q;
    assign last_issue = (k_q + 32'(LANES)) >= cur_k_q;
    assign wr_in    = en && cmd == 7'd1 && !busy;
    assign wr_flt   = en && cmd == 7'd2 && !busy;
    assign be       = (rw_bytes_q == 3'd1) ? 4'b0001 :
                      (rw_bytes_q == 3'd2) ? 4'b0011 : 4'b1111;
    assign ret      = ret_q;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // FSM: next state; a start overrides whatever the job was doing
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            S_RUN: begin
                if (last_issue) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end
            end
            S_DRAIN: begin
                if (drain_q) state_d = S_IDLE;
                else         drain_d = 1'b1;
            end
            default: ;
        endcase
        if (start) begin
            state_d = depth_ok ? S_RUN : S_DRAIN;
            drain_d = 1'b0;
        end
    end

    // FSM: outputs
    always_comb begin
        busy  = (state_q != S_IDLE);
        done  = (state_q == S_IDLE);
        issue = (state_q == S_RUN);
    end

    // Lane products; each lane reduces its own ring index so a group may straddle the wrap.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            if ((k_q + 32'(i)) < cur_k_q) begin
                lane_sum = lane_sum
                    + {{24{filt_mem[FA_W'(k_q + 32'(i))][7]}},
                       filt_mem[FA_W'(k_q + 32'(i))]}
                    * ({{24{ring_mem[RA_W'((ia_q + 32'(i)) % ring_div)][7]}},
                        ring_mem[RA_W'((ia_q + 32'(i)) % ring_div)]}
                       + run_off_q);
            end
        end
    end

    // Byte reads for the response; unread and out-of-range bytes return 0
    always_comb begin
        rd_in  = '0;
        rd_flt = '0;
        for (int j = 0; j < 4; j++) begin
            if (be[j] && ({1'b0, inp0} + 33'(j)) < 33'(RING_SZ))
                rd_in[8*j +: 8] = ring_mem[RA_W'({1'b0, inp0} + 33'(j))];
            if (be[j] && ({1'b0, inp0} + 33'(j)) < 33'(FILT_SZ))
                rd_flt[8*j +: 8] = filt_mem[FA_W'({1'b0, inp0} + 33'(j))];
        end
    end

    // Buffer writes, LSB first; contents survive reset
    always_ff @(posedge clk) begin
        for (int j = 0; j < 4; j++) begin
            if (wr_in && be[j] && ({1'b0, inp0} + 33'(j)) < 33'(RING_SZ))
                ring_mem[RA_W'({1'b0, inp0} + 33'(j))] <= inp1[8*j +: 8];
            if (wr_flt && be[j] && ({1'b0, inp0} + 33'(j)) < 33'(FILT_SZ))
                filt_mem[FA_W'({1'b0, inp0} + 33'(j))] <= inp1[8*j +: 8];
        end
    end

    // Command registers and response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ret_q      <= '0;
            err_q      <= 1'b0;
            offset_q   <= '0;
            depth_q    <= '0;
            start_x_q  <= '0;
            rw_bytes_q <= 3'd4;
        end else if (en) begin
            case (cmd)
                7'd0:        ret_q <= 32'(FILT_SZ);
                7'd1, 7'd2:  if (busy) err_q <= 1'b1;
                7'd3:        offset_q <= inp1;
                7'd5:        depth_q <= inp1;
                7'd6:        err_q <= !depth_ok;
                7'd7:        ret_q <= acc_q;
                7'd8:        start_x_q <= inp1;
                7'd9:        ret_q <= {30'b0, err_q, done};
                7'd10:       ret_q <= rd_in;
                7'd11:       ret_q <= rd_flt;
                7'd18: begin
                    if (inp1 == 32'd1)      rw_bytes_q <= 3'd1;
                    else if (inp1 == 32'd2) rw_bytes_q <= 3'd2;
                    else                    rw_bytes_q <= 3'd4;
                end
                7'd19: begin
                    err_q     <= !depth_ok;
                    start_x_q <= (start_x_q + 32'd1) % 32'(KERNEL_LENGTH + 1);
                end
                default:     ret_q <= '0;
            endcase
        end
    end

    // Two-stage MAC: stage 1 registers the lane sum, stage 2 accumulates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            s1_sum_q   <= '0;
            s1_v_q     <= 1'b0;
            k_q        <= '0;
            ia_q       <= '0;
            run_off_q  <= '0;
            cur_k_q    <= '0;
            cur_ring_q <= '0;
        end else if (start) begin
            acc_q     <= '0;
            s1_v_q    <= 1'b0;
            k_q       <= '0;
            ia_q      <= ia_start;
            run_off_q <= offset_q;
            cur_k_q   <= depth_ok ? new_k : 32'd0;
            cur_ring_q <= depth_ok ? new_ring : 32'd0;
        end else begin
            s1_v_q <= issue;
            if (issue) begin
                s1_sum_q <= lane_sum;
                k_q      <= k_q + 32'(LANES);
                ia_q     <= (ia_q + 32'(LANES)) % ring_div;
            end
            if (s1_v_q) acc_q <= acc_q + s1_sum_q;
        end
    end

endmodule

// File: tb/tb_conv1d_pipelined_engine.sv
// Directed bench for conv1d_pipelined_engine: LANES=8 and LANES=16 copies
// share one command stream; results and latencies checked against hand values.
module tb_conv1d_pipelined_engine;

    localparam int FILT_SZ = 1024;
    localparam int RING_SZ = 1152;

    logic        clk = 1'b0;
    logic        rst, en;
    logic [6:0]  cmd;
    logic [31:0] inp0, inp1;
    logic [31:0] ret8, ret16;
    logic        busy8, busy16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv1d_pipelined_engine #(
        .KERNEL_LENGTH(8), .MAX_INPUT_CHANNELS(128), .LANES(8), .INT32_SIZE(32)
    ) u_l8 (
        .clk(clk), .rst(rst), .en(en), .cmd(cmd), .inp0(inp0), .inp1(inp1),
        .ret(ret8), .busy(busy8)
    );

    conv1d_pipelined_engine #(
        .KERNEL_LENGTH(8), .MAX_INPUT_CHANNELS(128), .LANES(16), .INT32_SIZE(32)
    ) u_l16 (
        .clk(clk), .rst(rst), .en(en), .cmd(cmd), .inp0(inp0), .inp1(inp1),
        .ret(ret16), .busy(busy16)
    );

    typedef struct {
        string       name;
        int          depth;
        int          sx;
        logic [31:0] off;
        logic [7:0]  fval;
        bit          ramp;
        logic [7:0]  ival;
        logic [31:0] exp_acc;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check2(input string name, input logic [31:0] exp);
        check({name, "_l8"}, ret8, exp);
        check({name, "_l16"}, ret16, exp);
    endtask

    task automatic do_cmd(input logic [6:0] c, input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        en = 1'b1; cmd = c; inp0 = a; inp1 = v;
        @(posedge clk);
        #1;
        en = 1'b0; cmd = '0;
    endtask

    // e0 = edges already elapsed since the start edge
    task automatic wait_done(input string name, input int e0, input int n8, input int n16);
        int lat8, lat16;
        lat8 = -1;
        lat16 = -1;
        check({name, "_busy"}, 32'({busy16, busy8}), 32'd3);
        for (int e = e0 + 1; e <= 400 && (lat8 < 0 || lat16 < 0); e++) begin
            @(posedge clk);
            #1;
            if (!busy8 && lat8 < 0) lat8 = e;
            if (!busy16 && lat16 < 0) lat16 = e;
        end
        check({name, "_lat_l8"}, 32'(lat8), 32'(n8 + 2));
        check({name, "_lat_l16"}, 32'(lat16), 32'(n16 + 2));
    endtask

    task automatic fill(input int depth, input logic [7:0] fval, input bit ramp,
                        input logic [7:0] ival);
        int fn, rn;
        logic [31:0] v;
        fn = 8 * depth + 16;
        if (fn > FILT_SZ) fn = FILT_SZ;
        rn = 9 * depth;
        do_cmd(7'd18, 32'd0, 32'd4);
        for (int a = 0; a < fn; a += 4) do_cmd(7'd2, 32'(a), {4{fval}});
        for (int a = 0; a < rn; a += 4) begin
            v = ramp ? {8'(a + 3), 8'(a + 2), 8'(a + 1), 8'(a)} : {4{ival}};
            do_cmd(7'd1, 32'(a), v);
        end
    endtask

    initial begin
        vecs[0] = '{"d2_x0", 2, 0, 32'd0, 8'd1, 1'b1, 8'd0, 32'd120};
        vecs[1] = '{"d2_x5", 2, 5, 32'd0, 8'd1, 1'b1, 8'd0, 32'd136};
        vecs[2] = '{"d2_x6", 2, 6, 32'd0, 8'd1, 1'b1, 8'd0, 32'd132};
        vecs[3] = '{"d3_tail", 3, 0, 32'd3, 8'd2, 1'b0, 8'hFF, 32'd96};
        vecs[4] = '{"d1_neg", 1, 0, 32'hFFFF_FFFE, 8'hFD, 1'b0, 8'd5, 32'hFFFF_FFB8};
        vecs[5] = '{"d128_ovf", 128, 0, 32'h7FFF_FF00, 8'h7F, 1'b0, 8'h7F,
                    32'd1024 * (32'd127 * (32'd127 + 32'h7FFF_FF00))};

        rst = 1'b1; en = 1'b0; cmd = '0; inp0 = '0; inp1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check2("rst_ret", 32'd0);
        check("rst_busy", 32'({busy16, busy8}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_cmd(7'd9, 32'd0, 32'd0);
        check2("rst_status", 32'd1);
        do_cmd(7'd0, 32'd0, 32'd0);
        check2("filt_sz", 32'(FILT_SZ));
        do_cmd(7'd99, 32'd0, 32'd0);
        check2("bad_cmd", 32'd0);

        for (int t = 0; t < 6; t++) begin
            fill(vecs[t].depth, vecs[t].fval, vecs[t].ramp, vecs[t].ival);
            do_cmd(7'd3, 32'd0, vecs[t].off);
            do_cmd(7'd5, 32'd0, 32'(vecs[t].depth));
            do_cmd(7'd8, 32'd0, 32'(vecs[t].sx));
            do_cmd(7'd6, 32'd0, 32'd0);
            wait_done(vecs[t].name, 0, (8 * vecs[t].depth + 7) / 8,
                      (8 * vecs[t].depth + 15) / 16);
            do_cmd(7'd7, 32'd0, 32'd0);
            check2({vecs[t].name, "_acc"}, vecs[t].exp_acc);
            do_cmd(7'd9, 32'd0, 32'd0);
            check2({vecs[t].name, "_stat"}, 32'd1);
        end

        fill(2, 8'd1, 1'b1, 8'd0);
        do_cmd(7'd3, 32'd0, 32'd0);
        do_cmd(7'd5, 32'd0, 32'd2);

        do_cmd(7'd8, 32'd0, 32'd0);
        do_cmd(7'd6, 32'd0, 32'd0);
        do_cmd(7'd8, 32'd0, 32'd5);
        do_cmd(7'd6, 32'd0, 32'd0);
        wait_done("restart", 0, 2, 1);
        do_cmd(7'd7, 32'd0, 32'd0);
        check2("restart_acc", 32'd136);

        do_cmd(7'd8, 32'd0, 32'd0);
        do_cmd(7'd6, 32'd0, 32'd0);
        do_cmd(7'd3, 32'd0, 32'd100);
        wait_done("offlatch", 1, 2, 1);
        do_cmd(7'd7, 32'd0, 32'd0);
        check2("offlatch_acc", 32'd120);
        do_cmd(7'd3, 32'd0, 32'd0);

        do_cmd(7'd6, 32'd0, 32'd0);
        do_cmd(7'd1, 32'd0, 32'hAAAA_AAAA);
        wait_done("busywr", 1, 2, 1);
        do_cmd(7'd7, 32'd0, 32'd0);
        check2("busywr_acc", 32'd120);
        do_cmd(7'd9, 32'd0, 32'd0);
        check2("busywr_stat", 32'd3);
        do_cmd(7'd10, 32'd0, 32'd0);
        check2("busywr_buf", 32'h0302_0100);

        do_cmd(7'd8, 32'd0, 32'd8);
        do_cmd(7'd19, 32'd0, 32'd0);
        wait_done("adv8", 0, 2, 1);
        do_cmd(7'd7, 32'd0, 32'd0);
        check2("adv8_acc", 32'd124);
        do_cmd(7'd9, 32'd0, 32'd0);
        check2("adv8_stat", 32'd1);
        do_cmd(7'd19, 32'd0, 32'd0);
        wait_done("adv0", 0, 2, 1);
        do_cmd(7'd7, 32'd0, 32'd0);
        check2("adv0_acc", 32'd120);

        do_cmd(7'd5, 32'd0, 32'd0);
        do_cmd(7'd6, 32'd0, 32'd0);
        wait_done("dep0", 0, 0, 0);
        do_cmd(7'd7, 32'd0, 32'd0);
        check2("dep0_acc", 32'd0);
        do_cmd(7'd9, 32'd0, 32'd0);
        check2("dep0_stat", 32'd3);
        do_cmd(7'd5, 32'd0, 32'd129);
        do_cmd(7'd6, 32'd0, 32'd0);
        wait_done("dep129", 0, 0, 0);
        do_cmd(7'd9, 32'd0, 32'd0);
        check2("dep129_stat", 32'd3);

        do_cmd(7'd18, 32'd0, 32'd4);
        do_cmd(7'd2, 32'd4, 32'h1122_3344);
        do_cmd(7'd18, 32'd0, 32'd2);
        do_cmd(7'd2, 32'd5, 32'hDEAD_BEEF);
        do_cmd(7'd11, 32'd5, 32'd0);
        check2("rw2_read", 32'h0000_BEEF);
        do_cmd(7'd18, 32'd0, 32'd3);
        do_cmd(7'd11, 32'd4, 32'd0);
        check2("rw3as4_read", 32'h11BE_EF44);
        do_cmd(7'd1, 32'(RING_SZ - 2), 32'hCAFE_BABE);
        do_cmd(7'd10, 32'(RING_SZ - 2), 32'd0);
        check2("ring_edge", 32'h0000_BABE);
        do_cmd(7'd18, 32'd0, 32'd1);
        do_cmd(7'd11, 32'd4, 32'd0);
        check2("rw1_read", 32'h0000_0044);

        do_cmd(7'd5, 32'd0, 32'd2);
        do_cmd(7'd0, 32'd0, 32'd0);
        check2("pre_rst_ret", 32'(FILT_SZ));
        do_cmd(7'd6, 32'd0, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check2("mid_rst_ret", 32'd0);
        check("mid_rst_busy", 32'({busy16, busy8}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_cmd(7'd9, 32'd0, 32'd0);
        check2("mid_rst_stat", 32'd1);
        do_cmd(7'd7, 32'd0, 32'd0);
        check2("mid_rst_acc", 32'd0);
        do_cmd(7'd11, 32'd4, 32'd0);
        check2("mid_rst_rw", 32'h11BE_EF44);
        do_cmd(7'd6, 32'd0, 32'd0);
        wait_done("mid_rst_dep", 0, 0, 0);
        do_cmd(7'd9, 32'd0, 32'd0);
        check2("mid_rst_dep_stat", 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
